// File: rtl/positive_triggered_jk_flipflop.sv
// Rising-edge JK flip-flop bank with asynchronous active-high clear.
//   clk : system clock, state changes on the rising edge
//   rst : asynchronous clear, active-high, forces q to 0 while high
//   j   : per-bit set/toggle control, sampled on rising clk
//   k   : per-bit clear/toggle control, sampled on rising clk
//   q   : registered state
//   q_n : bitwise complement of q (combinational from q)
module positive_triggered_jk_flipflop #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  localparam int unsigned W = WIDTH;

  logic [W-1:0] q_next;

  // Per-bit JK decode. A case is used rather than the (j & ~q) | (~k & q)
  // equation so that set/clear define a bit even when q is still unknown.
  always_comb begin
    q_next = q;
    for (int i = 0; i < int'(W); i++) begin
      case ({j[i], k[i]})
        2'b01:   q_next[i] = 1'b0;
        2'b10:   q_next[i] = 1'b1;
        2'b11:   q_next[i] = ~q[i];
        default: q_next[i] = q[i];
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_positive_triggered_jk_flipflop.sv
// Directed bench for the JK flip-flop bank, 1-bit and 4-bit instances.
module tb_positive_triggered_jk_flipflop;

  logic       clk;
  logic       rst;
  logic [0:0] j1, k1, q1, qn1;
  logic [3:0] j4, k4, q4, qn4;

  int checks = 0;
  int errors = 0;

  positive_triggered_jk_flipflop #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .j(j1), .k(k1), .q(q1), .q_n(qn1)
  );

  positive_triggered_jk_flipflop #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .j(j4), .k(k4), .q(q4), .q_n(qn4)
  );

  // Rising edges at 10, 30, 50, ...
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive 1-bit j/k on the falling edge, then sample just after the next rising edge.
  task automatic step1(input logic jv, input logic kv);
    @(negedge clk);
    j1 = jv;
    k1 = kv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b0; k4 = 4'b0;
    #1;
    check("reset_q1", 64'(q1), 64'h0);
    check("reset_qn1", 64'(qn1), 64'h1);
    check("reset_q4", 64'(q4), 64'h0);
    check("reset_qn4", 64'(qn4), 64'hF);

    // Release reset on a falling edge
    @(negedge clk);
    rst = 1'b0;

    // Truth table
    step1(1'b0, 1'b1); check("tt_01", 64'(q1), 64'h0);
    step1(1'b1, 1'b0); check("tt_10", 64'(q1), 64'h1);
    check("tt_10_qn", 64'(qn1), 64'h0);
    step1(1'b0, 1'b0); check("tt_00", 64'(q1), 64'h1);
    step1(1'b1, 1'b1); check("tt_11a", 64'(q1), 64'h0);
    check("tt_11a_qn", 64'(qn1), 64'h1);
    step1(1'b1, 1'b1); check("tt_11b", 64'(q1), 64'h1);

    // Async reset mid-cycle with q = 1
    @(negedge clk);
    j1 = 1'b0; k1 = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("async_q", 64'(q1), 64'h0);
    check("async_qn", 64'(qn1), 64'h1);
    check("async_clk_low", 64'(clk), 64'h0);
    step1(1'b0, 1'b0); check("rst_hold_00", 64'(q1), 64'h0);
    step1(1'b0, 1'b1); check("rst_hold_01", 64'(q1), 64'h0);
    step1(1'b1, 1'b0); check("rst_hold_10", 64'(q1), 64'h0);
    step1(1'b1, 1'b1); check("rst_hold_11", 64'(q1), 64'h0);
    check("rst_hold_qn", 64'(qn1), 64'h1);

    // Toggle divider: release with j=k=1
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("div_%0d", i), 64'(q1), ((i % 2) == 0) ? 64'h1 : 64'h0);
    end

    // Reset release 1 ns before a rising edge with j=1, k=0
    @(negedge clk);
    rst = 1'b1;
    j1 = 1'b1; k1 = 1'b0;
    #1;
    check("rel_pre", 64'(q1), 64'h0);
    @(posedge clk);
    #1;
    check("rel_held", 64'(q1), 64'h0);
    @(negedge clk);
    #9;
    rst = 1'b0;
    #0.5;
    check("rel_wait", 64'(q1), 64'h0);
    @(posedge clk);
    #1;
    check("rel_edge", 64'(q1), 64'h1);
    check("rel_q4", 64'(q4), 64'h0);

    // Multi-bit: set / clear / toggle / hold in one vector
    @(negedge clk);
    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b1010; k4 = 4'b0110;
    @(posedge clk);
    #1;
    check("mb_edge1", 64'(q4), 64'hA);
    check("mb_edge1_qn", 64'(qn4), 64'h5);
    @(posedge clk);
    #1;
    check("mb_edge2", 64'(q4), 64'h8);
    check("mb_edge2_qn", 64'(qn4), 64'h7);
    check("mb_q1_hold", 64'(q1), 64'h1);

    // Falling-edge immunity: toggle controls present only across the falling edge
    @(negedge clk);
    j4 = 4'b0000; k4 = 4'b0000;
    @(posedge clk);
    #2;
    j1 = 1'b1; k1 = 1'b1;
    j4 = 4'b1111; k4 = 4'b1111;
    @(negedge clk);
    #1;
    check("fall_q1", 64'(q1), 64'h1);
    check("fall_q4", 64'(q4), 64'h8);
    j1 = 1'b0; k1 = 1'b0;
    j4 = 4'b0000; k4 = 4'b0000;
    @(posedge clk);
    #1;
    check("fall_next_q1", 64'(q1), 64'h1);
    check("fall_next_q4", 64'(q4), 64'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
